// File: rtl/minsoc_spi_flash_loader.sv
// Boot loader: reads a length-prefixed image from SPI flash (READ 0x03, mode 0)
// and writes it into a word-addressed RAM as big-endian 32-bit words.
module minsoc_spi_flash_loader #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned ADR_W     = 13,
  parameter logic [23:0] FLASH_ADR = 24'h000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             spi_flash_sclk,
  output logic             spi_flash_mosi,
  input  logic             spi_flash_miso,
  output logic             spi_flash_ss,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_dat,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, FINISH} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [33:0] CAPACITY = 34'd4 << ADR_W;
  localparam logic [31:0] READ_CMD = {8'h03, FLASH_ADR};

  state_t r_state, w_nextState;

  logic [7:0]       r_divCnt;
  logic             r_sclk;
  logic [31:0]      r_mosiSh;
  logic [4:0]       r_bitCnt;
  logic [31:0]      r_shift;
  logic [31:0]      r_byteCnt;
  logic [ADR_W-1:0] r_wordCnt;
  logic [31:0]      r_len;
  logic [33:0]      r_effLen;
  logic             r_ss;
  logic             r_memWe;
  logic [ADR_W-1:0] r_memAdr;
  logic [31:0]      r_memDat;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic        w_divEnd;
  logic        w_active;
  logic        w_rise;
  logic        w_fall;
  logic        w_cmdDone;
  logic        w_byteDone;
  logic        w_isLenByte;
  logic [33:0] w_lenMax4;
  logic [33:0] w_rounded;
  logic        w_over;
  logic [33:0] w_effNew;
  logic [33:0] w_effLen;
  logic [33:0] w_byteIdx;
  logic        w_lastByte;
  logic        w_padByte;
  logic [7:0]  w_newByte;
  logic [31:0] w_word;
  logic        w_wordDone;

  always_comb begin
    w_divEnd    = (r_divCnt == DIV_LAST);
    w_active    = (r_state == CMD) || (r_state == DATA);
    w_rise      = w_active && w_divEnd && !r_sclk;
    w_fall      = w_active && w_divEnd && r_sclk;
    w_cmdDone   = (r_state == CMD) && w_fall && (r_bitCnt == 5'd31);
    w_byteDone  = (r_state == DATA) && w_fall && (r_bitCnt[2:0] == 3'd7);
    w_isLenByte = (r_byteCnt == 32'd3);
    // The length word is complete in r_shift when its 4th byte finishes,
    // so the effective length must be usable in that same cycle.
    w_lenMax4   = (r_shift < 32'd4) ? 34'd4 : {2'b00, r_shift};
    w_rounded   = (w_lenMax4 + 34'd3) & ~34'd3;
    w_over      = (w_rounded > CAPACITY);
    w_effNew    = w_over ? CAPACITY : w_rounded;
    w_effLen    = w_isLenByte ? w_effNew : r_effLen;
    w_byteIdx   = {2'b00, r_byteCnt} + 34'd1;
    w_lastByte  = w_byteDone && (r_byteCnt >= 32'd3) && (w_byteIdx == w_effLen);
    w_padByte   = (r_byteCnt >= 32'd4) && (r_byteCnt >= r_len);
    w_newByte   = w_padByte ? 8'h00 : r_shift[7:0];
    w_word      = {r_shift[31:8], w_newByte};
    w_wordDone  = w_byteDone && (r_byteCnt[1:0] == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start)      w_nextState = CMD;
      CMD:     if (w_cmdDone)  w_nextState = DATA;
      DATA:    if (w_lastByte) w_nextState = FINISH;
      FINISH:  if (w_divEnd)   w_nextState = IDLE;
      default:                 w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_divCnt  <= '0;
      r_sclk    <= 1'b0;
      r_mosiSh  <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_byteCnt <= '0;
      r_wordCnt <= '0;
      r_len     <= '0;
      r_effLen  <= '0;
      r_ss      <= 1'b1;
      r_memWe   <= 1'b0;
      r_memAdr  <= '0;
      r_memDat  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_memWe <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ss      <= 1'b0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_byteCnt <= '0;
            r_wordCnt <= '0;
            r_divCnt  <= '0;
            r_sclk    <= 1'b0;
            r_bitCnt  <= '0;
            r_mosiSh  <= READ_CMD;
          end
        end
        CMD, DATA: begin
          if (w_divEnd) begin
            r_divCnt <= '0;
            r_sclk   <= ~r_sclk;
          end else begin
            r_divCnt <= r_divCnt + 8'd1;
          end
          if (w_rise && (r_state == DATA))
            r_shift <= {r_shift[30:0], spi_flash_miso};
          // Zeros shift into MOSI, so it idles low once the command is out.
          if (w_fall) begin
            r_bitCnt <= r_bitCnt + 5'd1;
            r_mosiSh <= {r_mosiSh[30:0], 1'b0};
          end
          if (w_byteDone) begin
            r_shift[7:0] <= w_newByte;
            r_byteCnt    <= r_byteCnt + 32'd1;
            if (w_isLenByte) begin
              r_len    <= r_shift;
              r_effLen <= w_effNew;
              r_err    <= w_over;
            end
            if (w_wordDone) begin
              r_memWe  <= 1'b1;
              r_memDat <= w_word;
              r_memAdr <= r_wordCnt;
              if (!w_lastByte) r_wordCnt <= r_wordCnt + ADR_W'(1);
            end
          end
        end
        FINISH: begin
          if (w_divEnd) begin
            r_divCnt <= '0;
            r_ss     <= 1'b1;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_divCnt <= r_divCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_flash_sclk = r_sclk;
  assign spi_flash_mosi = r_mosiSh[31];
  assign spi_flash_ss   = r_ss;
  assign mem_we         = r_memWe;
  assign mem_adr        = r_memAdr;
  assign mem_dat        = r_memDat;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_minsoc_spi_flash_loader.sv
// Scoreboard bench for the SPI flash loader: a behavioural flash feeds random
// images while a monitor checks RAM writes and completion against a reference.
module tb_minsoc_spi_flash_loader;

  localparam int          CLK_DIV   = 2;
  localparam int          ADR_W     = 2;
  localparam logic [23:0] FLASH_ADR = 24'h012345;
  localparam int          CAP_BYTES = 4 << ADR_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sclk;
  logic             mosi;
  logic             miso = 1'b0;
  logic             ss;
  logic             memWe;
  logic [ADR_W-1:0] memAdr;
  logic [31:0]      memDat;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  minsoc_spi_flash_loader #(
    .CLK_DIV  (CLK_DIV),
    .ADR_W    (ADR_W),
    .FLASH_ADR(FLASH_ADR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .spi_flash_sclk(sclk),
    .spi_flash_mosi(mosi),
    .spi_flash_miso(miso),
    .spi_flash_ss  (ss),
    .mem_we        (memWe),
    .mem_adr       (memAdr),
    .mem_dat       (memDat),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat;
  } word_t;

  typedef struct {
    logic err;
    int   dataBits;
  } load_t;

  int          compared   = 0;
  int          mismatched = 0;
  word_t       expWords[$];
  load_t       expLoads[$];
  logic [7:0]  flashImg[$];
  int          doneCount  = 0;

  int          flashBits   = 0;
  logic [31:0] flashCmd    = '0;
  int          periodErrs  = 0;
  int          ssHighRises = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic flashBit(input int d);
    int         idx;
    logic [7:0] b;
    idx = d / 8;
    b   = (idx < flashImg.size()) ? flashImg[idx] : 8'hFF;
    return b[7 - (d % 8)];
  endfunction

  // Behavioural SPI mode-0 flash: captures the command on SCLK rises and
  // presents image bits on SCLK falls once 32 command bits are in.
  always @(negedge clk) begin
    static logic prevSclk = 1'b0;
    static logic prevSs   = 1'b1;
    static int   tbCycle  = 0;
    static int   lastRise = -1;
    tbCycle++;
    if (!ss && prevSs) begin
      flashBits  = 0;
      flashCmd   = '0;
      periodErrs = 0;
      lastRise   = -1;
    end
    if (sclk && !prevSclk) begin
      if (ss) begin
        ssHighRises++;
      end else begin
        if (flashBits < 32) flashCmd = {flashCmd[30:0], mosi};
        if (lastRise >= 0 && (tbCycle - lastRise) != 2 * CLK_DIV) periodErrs++;
        lastRise = tbCycle;
        flashBits++;
      end
    end
    if (!sclk && prevSclk && !ss && flashBits >= 32)
      miso = flashBit(flashBits - 32);
    prevSclk = sclk;
    prevSs   = ss;
  end

  // Monitor: pops the scoreboard on every RAM write and every done pulse.
  always @(negedge clk) begin
    word_t w;
    load_t l;
    if (memWe) begin
      if (expWords.size() == 0) begin
        checkOutput("unexpectedWrite", {1'b1, memAdr}, 0);
      end else begin
        w = expWords.pop_front();
        checkOutput("memAdr", memAdr, w.adr);
        checkOutput("memDat", memDat, w.dat);
      end
    end
    if (done) begin
      doneCount++;
      if (expLoads.size() == 0) begin
        checkOutput("unexpectedDone", done, 0);
      end else begin
        l = expLoads.pop_front();
        checkOutput("errAtDone", err, l.err);
        checkOutput("wordsLeftAtDone", expWords.size(), 0);
        checkOutput("cmdBits", flashCmd, {8'h03, FLASH_ADR});
        checkOutput("dataBits", flashBits - 32, l.dataBits);
        checkOutput("sclkPeriodErrs", periodErrs, 0);
        checkOutput("ssHighAtDone", ss, 1);
        checkOutput("busyAtDone", busy, 0);
      end
    end
  end

  task automatic waitDone(input int target);
    bit seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (doneCount >= target) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("doneTimeout", doneCount, target);
    @(negedge clk);
  endtask

  // Builds an image, predicts every RAM write from the length rules and runs one load.
  task automatic applyStimulus(input logic [31:0] len, input bit doubleStart);
    longint      eff;
    bit          expErr;
    int          target;
    word_t       w;
    load_t       l;
    logic [31:0] word;
    logic [7:0]  v;
    flashImg.delete();
    flashImg.push_back(len[31:24]);
    flashImg.push_back(len[23:16]);
    flashImg.push_back(len[15:8]);
    flashImg.push_back(len[7:0]);
    eff    = (len < 32'd4) ? 64'd4 : longint'(len);
    eff    = ((eff + 3) / 4) * 4;
    expErr = (eff > CAP_BYTES);
    if (expErr) eff = CAP_BYTES;
    for (longint i = 4; i < eff + 4; i++) flashImg.push_back(8'($urandom));
    for (int wi = 0; wi < int'(eff / 4); wi++) begin
      word = '0;
      for (int b = 0; b < 4; b++) begin
        int idx = 4 * wi + b;
        v = (idx >= 4 && longint'(idx) >= longint'(len)) ? 8'h00 : flashImg[idx];
        word = {word[23:0], v};
      end
      w.adr = ADR_W'(wi);
      w.dat = word;
      expWords.push_back(w);
    end
    l.err      = expErr;
    l.dataBits = int'(eff) * 8;
    expLoads.push_back(l);
    target = doneCount + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("errClearedAtStart", err, 0);
    checkOutput("ssLowAfterStart", ss, 0);
    if (doubleStart) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitDone(target);
    if (doubleStart) begin
      repeat (40) @(negedge clk);
      checkOutput("singleDone", doneCount, target);
      checkOutput("idleAfterDoubleStart", busy, 0);
    end
    repeat ($urandom_range(2, 10)) @(negedge clk);
  endtask

  task automatic abortWithReset();
    bit reached = 0;
    flashImg.delete();
    flashImg = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h5A, 8'hA5, 8'h3C, 8'hC3};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (flashBits >= 32 + 19) begin
        reached = 1;
        break;
      end
    end
    if (!reached) checkOutput("thirdByteTimeout", flashBits, 32 + 19);
    reset = 1'b1;
    expWords.delete();
    expLoads.delete();
    @(negedge clk);
    checkOutput("abortSs", ss, 1);
    checkOutput("abortSclk", sclk, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortMemWe", memWe, 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("abortStillIdle", {busy, ss}, 2'b01);
  endtask

  initial begin
    logic [31:0] len;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetSclk", sclk, 0);
    checkOutput("resetMosi", mosi, 0);
    checkOutput("resetSs", ss, 1);
    checkOutput("resetMemWe", memWe, 0);
    checkOutput("resetMemAdr", memAdr, 0);
    checkOutput("resetMemDat", memDat, 0);
    checkOutput("resetBusyDoneErr", {busy, done, err}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idleWaitsForStart", {busy, ss}, 2'b01);

    $display("[TB] directed loads");
    applyStimulus(32'h0000000C, 1'b0);
    applyStimulus(32'h00000006, 1'b0);
    applyStimulus(32'h00000100, 1'b0);
    applyStimulus(32'h00000008, 1'b0);
    applyStimulus(32'h00000010, 1'b1);
    applyStimulus(32'h00000000, 1'b0);
    applyStimulus(32'hFFFFFFFF, 1'b0);

    $display("[TB] reset during data phase");
    abortWithReset();
    applyStimulus(32'h0000000C, 1'b0);

    $display("[TB] randomized loads");
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0:       len = 32'($urandom_range(0, 4));
        1:       len = 32'($urandom_range(5, 16));
        2:       len = 32'($urandom_range(17, 40));
        default: len = $urandom;
      endcase
      applyStimulus(len, 1'($urandom_range(0, 1)));
    end

    checkOutput("noSclkWithSsHigh", ssHighRises, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
